countdown_ctrl: RTL and testbench

Control stage directly upstream of the 4-bit down counter. Drives the counter's enable and synchronous clear, monitors its count output, and counts completed laps (0 -> 4'hF wrap events). Stops the counter after a programmed number of laps and reports completion with a one-cycle pulse. An optional pause input is available at compile time.

---
 rtl/countdown_ctrl.sv | 112 +++++++++++
 tb/tb_countdown_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run controller for a 4-bit down counter.
// Clears the counter, enables it, counts 0 -> 4'hF wrap events (laps),
// stops after LAPS laps and pulses done for one cycle.
// Optional feature macro: COUNTDOWN_CTRL_PAUSE_EN (builds the PAUSE state
// and honours the pause input). Without it, pause is accepted but ignored.
// Handshake: start is a level request sampled on every rising edge but acted
// on only in IDLE; there is no ready/ack, busy high means a run is underway.
// All outputs are decoded from the state register; dbg_state exposes the
// raw state encoding for observation.
module countdown_ctrl #(
  parameter int LAPS  = 2,
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [3:0]       q_in,
  output logic             cnt_en,
  output logic             cnt_reset,
  output logic             busy,
  output logic             done,
  output logic [LAP_W-1:0] laps,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
`ifdef COUNTDOWN_CTRL_PAUSE_EN
    S_PAUSE = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LAP_W-1:0] LAPS_V = LAP_W'(LAPS);

  state_t           state;
  state_t           state_nxt;
  logic             lap;
  logic [LAP_W-1:0] laps_inc;

`ifndef COUNTDOWN_CTRL_PAUSE_EN
  // pause has no effect in this build; the port stays for interface stability
  logic pause_unused;
  assign pause_unused = pause;
`endif

  // A lap is the counter sitting at zero while enabled; it wraps at this edge
  assign lap      = (state == S_RUN) && (q_in == 4'h0);
  assign laps_inc = laps + LAP_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; the final lap wins over a pause request
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN: begin
        if (lap && (laps_inc == LAPS_V)) state_nxt = S_DONE;
`ifdef COUNTDOWN_CTRL_PAUSE_EN
        else if (pause)                  state_nxt = S_PAUSE;
`endif
      end
`ifdef COUNTDOWN_CTRL_PAUSE_EN
      S_PAUSE: if (!pause) state_nxt = S_RUN;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lap counter: cleared in LOAD, bumped on each lap, held otherwise
  always_ff @(posedge clk) begin
    if (reset)                laps <= '0;
    else if (state == S_LOAD) laps <= '0;
    else if (lap)             laps <= laps_inc;
  end

  // Moore output decode; cnt_reset and cnt_en come from disjoint states
  always_comb begin
    cnt_en    = 1'b0;
    cnt_reset = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_LOAD: begin
        cnt_reset = 1'b1;
        busy      = 1'b1;
      end
      S_RUN: begin
        cnt_en = 1'b1;
        busy   = 1'b1;
      end
`ifdef COUNTDOWN_CTRL_PAUSE_EN
      S_PAUSE: busy = 1'b1;
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: one instance with LAPS=1 and one with
// LAPS=2, each driving its own behavioural 4-bit down counter.
// Cycle k is the interval after the k-th rising edge counted from the edge
// that samples start (cycle 0 is where start is high).
module tb_countdown_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // clock / reset block
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start1, start2, pause1, pause2;
  logic       en1, clr1, busy1, done1;
  logic       en2, clr2, busy2, done2;
  logic [3:0] laps1, laps2;
  logic [2:0] dbg1, dbg2;
  logic [3:0] q1 = 4'h5;
  logic [3:0] q2 = 4'h5;

  int checks = 0;
  int errors = 0;

  countdown_ctrl #(.LAPS(1), .LAP_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pause(pause1), .q_in(q1),
    .cnt_en(en1), .cnt_reset(clr1), .busy(busy1), .done(done1),
    .laps(laps1), .dbg_state(dbg1)
  );

  countdown_ctrl #(.LAPS(2), .LAP_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .pause(pause2), .q_in(q2),
    .cnt_en(en2), .cnt_reset(clr2), .busy(busy2), .done(done2),
    .laps(laps2), .dbg_state(dbg2)
  );

  // behavioural down counters (no reset of their own)
  always @(posedge clk) begin
    if (clr1)     q1 <= 4'h0;
    else if (en1) q1 <= q1 - 4'h1;
    if (clr2)     q2 <= 4'h0;
    else if (en2) q2 <= q2 - 4'h1;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_d1(input int k, input logic [2:0] st, input logic [3:0] l,
                        input logic [3:0] q);
    chk("d1_state", k, 32'(dbg1), 32'(st));
    chk("d1_cnt_en", k, 32'(en1), 32'(st == S_RUN));
    chk("d1_cnt_reset", k, 32'(clr1), 32'(st == S_LOAD));
    chk("d1_busy", k, 32'(busy1), 32'(st == S_LOAD || st == S_RUN || st == S_PAUSE));
    chk("d1_done", k, 32'(done1), 32'(st == S_DONE));
    chk("d1_laps", k, 32'(laps1), 32'(l));
    chk("d1_q", k, 32'(q1), 32'(q));
  endtask

  task automatic chk_d2(input int k, input logic [2:0] st, input logic [3:0] l,
                        input logic [3:0] q);
    chk("d2_state", k, 32'(dbg2), 32'(st));
    chk("d2_cnt_en", k, 32'(en2), 32'(st == S_RUN));
    chk("d2_cnt_reset", k, 32'(clr2), 32'(st == S_LOAD));
    chk("d2_busy", k, 32'(busy2), 32'(st == S_LOAD || st == S_RUN || st == S_PAUSE));
    chk("d2_done", k, 32'(done2), 32'(st == S_DONE));
    chk("d2_laps", k, 32'(laps2), 32'(l));
    chk("d2_q", k, 32'(q2), 32'(q));
  endtask

  // Hand-derived expectations for a LAPS=2 run started in cycle 0.
  // pl/pq: laps and counter value carried in from before the run.
  task automatic exp_run2(input int k, input bit paused, input logic [3:0] pl,
                          input logic [3:0] pq, output logic [2:0] st,
                          output logic [3:0] l, output logic [3:0] q);
    st = S_IDLE; l = 4'd2; q = 4'hF;
    if (k == 1) begin
      st = S_LOAD; l = pl; q = pq;
    end else if (k == 2) begin
      st = S_RUN; l = 4'd0; q = 4'h0;
    end else if (!paused) begin
      if (k <= 18)      begin st = S_RUN;  l = 4'd1; q = 4'(18 - k); end
      else if (k == 19) begin st = S_DONE; l = 4'd2; q = 4'hF; end
    end else begin
      if (k <= 7)       begin st = S_RUN;   l = 4'd1; q = 4'(18 - k); end
      else if (k <= 12) begin st = S_PAUSE; l = 4'd1; q = 4'hA; end
      else if (k <= 23) begin st = S_RUN;   l = 4'd1; q = 4'(23 - k); end
      else if (k == 24) begin st = S_DONE;  l = 4'd2; q = 4'hF; end
    end
  endtask

  logic [2:0] est;
  logic [3:0] el, eq;
  bit         pause_built;

  initial begin
`ifdef COUNTDOWN_CTRL_PAUSE_EN
    pause_built = 1'b1;
`else
    pause_built = 1'b0;
`endif
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; pause1 = 1'b0; pause2 = 1'b0;

    // reset held two cycles, then released with start low
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_d1(0, S_IDLE, 4'd0, 4'h5);
    chk_d2(0, S_IDLE, 4'd0, 4'h5);

    // single-lap and two-lap runs together, stray starts on dut2 in RUN/DONE
    start1 = 1'b1; start2 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1)      chk_d1(k, S_LOAD, 4'd0, 4'h5);
      else if (k == 2) chk_d1(k, S_RUN,  4'd0, 4'h0);
      else if (k == 3) chk_d1(k, S_DONE, 4'd1, 4'hF);
      else             chk_d1(k, S_IDLE, 4'd1, 4'hF);
      exp_run2(k, 1'b0, 4'd0, 4'h5, est, el, eq);
      chk_d2(k, est, el, eq);
      start1 = 1'b0;
      start2 = (k == 10 || k == 19);
    end

    // pause for five sampled cycles (7..11) on the LAPS=2 instance
    start2 = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_run2(k, pause_built, 4'd2, 4'hF, est, el, eq);
      chk_d2(k, est, el, eq);
      chk_d1(k, S_IDLE, 4'd1, 4'hF);
      start2 = 1'b0;
      pause2 = (k >= 7 && k <= 11);
    end

    // reset asserted in cycle 10 of a run
    start2 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_run2(k, 1'b0, 4'd2, 4'hF, est, el, eq);
      chk_d2(k, est, el, eq);
      start2 = 1'b0;
    end
    reset = 1'b1;
    tick();
    chk_d2(11, S_IDLE, 4'd0, 4'h7);
    chk_d1(11, S_IDLE, 4'd0, 4'hF);
    reset = 1'b0;
    tick();
    chk_d2(12, S_IDLE, 4'd0, 4'h7);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
